dtree_feature_loader: RTL and testbench

DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

---
 rtl/dtree_pkg.sv | 7 +
 rtl/dtree_feat_shreg.sv | 28 ++
 rtl/dtree_feature_loader.sv | 76 +++++++
 tb/tb_dtree_feature_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// dtree_pkg: shared defaults and FSM state encoding for the decision-tree feature loader.
package dtree_pkg;
    localparam int NUM_FEAT_DEF = 4;
    localparam int FEAT_W_DEF   = 8;
    localparam int CLASS_W_DEF  = 2;
    typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;
endpackage

// File: rtl/dtree_feat_shreg.sv
// dtree_feat_shreg: feature slot register file with auto-incrementing write index.
module dtree_feat_shreg #(
    parameter int NUM_FEAT = 4,
    parameter int FEAT_W   = 8,
    parameter int IDX_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic                       restart_i,
    input  logic [FEAT_W-1:0]          data_i,
    output logic [IDX_W-1:0]           idx_o,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_o
);
    logic [IDX_W-1:0]           idx_q;
    logic [NUM_FEAT*FEAT_W-1:0] feat_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            feat_q <= '0;
        end else if (we_i) begin
            feat_q[idx_q*FEAT_W +: FEAT_W] <= data_i;
            idx_q                          <= restart_i ? '0 : idx_q + 1'b1;
        end
    end
    assign idx_o  = idx_q;
    assign feat_o = feat_q;
endmodule

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: collects a feature byte stream, holds it for an external
// combinational decision tree, and returns the registered class over a handshake.
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int NUM_FEAT = NUM_FEAT_DEF,
    parameter int FEAT_W   = FEAT_W_DEF,
    parameter int CLASS_W  = CLASS_W_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEAT_W-1:0]          in_data,
    input  logic                       in_last,
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]         tree_class,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CLASS_W-1:0]         out_class,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           sample_cnt
);
    localparam int IDX_W = NUM_FEAT > 1 ? $clog2(NUM_FEAT) : 1;
    state_t             state_q;
    logic               out_valid_q, frame_err_q;
    logic [CLASS_W-1:0] out_class_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx;
    logic               accept, at_end, good, bad;
    assign in_ready = state_q == COLLECT;
    assign accept   = in_valid && in_ready;
    assign at_end   = idx == IDX_W'(NUM_FEAT - 1);
    assign good     = accept && in_last && at_end;
    // a last flag off the final slot, or a final slot without last, is malformed
    assign bad      = accept && (in_last ^ at_end);
    dtree_feat_shreg #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .IDX_W(IDX_W)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .we_i      (accept),
        .restart_i (in_last || at_end),
        .data_i    (in_data),
        .idx_o     (idx),
        .feat_o    (feat_bus)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            frame_err_q <= bad;
            case (state_q)
                COLLECT: if (good) state_q <= EVAL;
                EVAL: begin
                    out_class_q <= tree_class;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= COLLECT;
                    if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign frame_err  = frame_err_q;
    assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb_dtree_feature_loader: directed checks of dtree_feature_loader with CNT_W=2.
module tb_dtree_feature_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic [31:0] feat_bus;
    logic [1:0]  tree_class = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_class;
    logic        frame_err;
    logic [1:0]  sample_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dtree_feature_loader #(.NUM_FEAT(4), .FEAT_W(8), .CLASS_W(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .feat_bus   (feat_bus),
        .tree_class (tree_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .frame_err  (frame_err),
        .sample_cnt (sample_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        chk("beat_in_ready", 64'(in_ready), 64'h1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w, input logic last4);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] t;
            t = w >> (8 * b);
            beat(t[7:0], b == 3 ? last4 : 1'b0);
        end
    endtask

    task automatic result(input string tag, input logic [1:0] cls, input logic [1:0] cnt);
        chk({tag, "_eval_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_eval_ready"}, 64'(in_ready), 64'h0);
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'h1);
        chk({tag, "_class"}, 64'(out_class), 64'(cls));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_done_ready"}, 64'(in_ready), 64'h1);
        chk({tag, "_cnt"}, 64'(sample_cnt), 64'(cnt));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_feat_bus", 64'(feat_bus), 64'h0);
        chk("rst_out_class", 64'(out_class), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        chk("rst_cnt", 64'(sample_cnt), 64'h0);

        // basic sample, then stall in HOLD with toggling tree_class and offered beats
        tree_class = 2'd2;
        send4(32'hC380_5510, 1'b1);
        chk("s1_feat_bus", 64'(feat_bus), 64'hC380_5510);
        chk("s1_eval_valid", 64'(out_valid), 64'h0);
        step();
        chk("s1_valid", 64'(out_valid), 64'h1);
        chk("s1_class", 64'(out_class), 64'h2);
        for (int i = 0; i < 5; i++) begin
            tree_class = 2'(i);
            in_valid   = 1'b1;
            in_data    = 8'hFF;
            step();
            chk("hold_valid", 64'(out_valid), 64'h1);
            chk("hold_class", 64'(out_class), 64'h2);
            chk("hold_in_ready", 64'(in_ready), 64'h0);
            chk("hold_feat_bus", 64'(feat_bus), 64'hC380_5510);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("s1_done_valid", 64'(out_valid), 64'h0);
        chk("s1_cnt", 64'(sample_cnt), 64'h1);
        chk("s1_in_ready", 64'(in_ready), 64'h1);

        // early in_last on 2nd beat
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b1);
        chk("early_err", 64'(frame_err), 64'h1);
        chk("early_valid", 64'(out_valid), 64'h0);
        chk("early_in_ready", 64'(in_ready), 64'h1);
        step();
        chk("early_err_clear", 64'(frame_err), 64'h0);
        chk("early_no_valid", 64'(out_valid), 64'h0);
        tree_class = 2'd1;
        send4(32'hD4C3_B2A1, 1'b1);
        chk("s2_feat_bus", 64'(feat_bus), 64'hD4C3_B2A1);
        chk("s2_no_err", 64'(frame_err), 64'h0);
        result("s2", 2'd1, 2'd2);

        // missing in_last on 4th beat
        send4(32'h4433_2211, 1'b0);
        chk("miss_err", 64'(frame_err), 64'h1);
        chk("miss_feat_bus", 64'(feat_bus), 64'h4433_2211);
        chk("miss_in_ready", 64'(in_ready), 64'h1);
        step();
        chk("miss_err_clear", 64'(frame_err), 64'h0);
        chk("miss_cnt", 64'(sample_cnt), 64'h2);
        tree_class = 2'd3;
        send4(32'h0807_0605, 1'b1);
        chk("s3_feat_bus", 64'(feat_bus), 64'h0807_0605);
        result("s3", 2'd3, 2'd3);

        // reset mid-sample
        beat(8'h99, 1'b0);
        beat(8'h98, 1'b0);
        beat(8'h97, 1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst_feat", 64'(feat_bus), 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_class", 64'(out_class), 64'h0);
        chk("mid_rst_err", 64'(frame_err), 64'h0);
        chk("mid_rst_cnt", 64'(sample_cnt), 64'h0);
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
        tree_class = 2'd2;
        send4(32'h0403_0201, 1'b1);
        chk("s4_feat_bus", 64'(feat_bus), 64'h0403_0201);
        chk("s4_no_err", 64'(frame_err), 64'h0);
        result("s4", 2'd2, 2'd1);

        // back-to-back with out_ready held: 6 cycles per sample, counter saturates
        out_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tree_class = 2'(s);
            for (int b = 0; b < 4; b++) begin
                chk("b2b_in_ready", 64'(in_ready), 64'h1);
                in_valid = 1'b1;
                in_data  = 8'(16 * s + b);
                in_last  = b == 3;
                step();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("b2b_eval_valid", 64'(out_valid), 64'h0);
            step();
            chk("b2b_valid", 64'(out_valid), 64'h1);
            chk("b2b_class", 64'(out_class), 64'(s[1:0]));
            step();
            chk("b2b_done_valid", 64'(out_valid), 64'h0);
            chk("b2b_cnt", 64'(sample_cnt), s >= 1 ? 64'h3 : 64'h2);
        end
        out_ready = 1'b0;
        chk("b2b_feat_bus", 64'(feat_bus), 64'h4342_4140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
